// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution window feeder.
// Holds the FSM state encoding, default geometry constants and the
// buffer address helper used by the window address generator.
package conv_pkg;

  localparam int DATA_W = 8;
  localparam int K      = 3;
  localparam int KK     = K * K;

  typedef enum logic [2:0] {
    IDLE,
    FEED,
    DRAIN,
    WAIT_PE,
    EMIT,
    DONE
  } state_t;

  // Row-major buffer address of kernel tap (kr,kc) for the window whose
  // top-left pixel is (row,col). The caller truncates to its address width.
  function automatic int unsigned addr_of(input int unsigned row,
                                          input int unsigned col,
                                          input int unsigned kr,
                                          input int unsigned kc,
                                          input int unsigned img_w);
    return (row + kr) * img_w + (col + kc);
  endfunction

endpackage

// File: rtl/conv_window_addr_gen.sv
// Window/kernel counters and feature-map buffer address for the feeder.
// Latency: address is combinational from the counters; counters update on clk.
// Backpressure: counters only move on k_step / win_adv, so the caller stalls them.
// Ports: clk, rst (sync, active-low); clr zeroes all counters; k_step advances
//   the kernel tap; win_adv advances the window (row-major); k_idx/k_last give
//   the current tap; row/col/win_last give the window; addr is the read address.
module conv_window_addr_gen
  import conv_pkg::*;
#(
  parameter int IMG_W  = 5,
  parameter int IMG_H  = 5,
  parameter int K      = conv_pkg::K,
  parameter int ADDR_W = $clog2(IMG_W * IMG_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              k_step,
  input  logic              win_adv,
  output logic [3:0]        k_idx,
  output logic              k_last,
  output logic              win_last,
  output logic [3:0]        row,
  output logic [3:0]        col,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [3:0] OH_LAST = 4'(IMG_H - K);
  localparam logic [3:0] OW_LAST = 4'(IMG_W - K);
  localparam logic [3:0] K_LAST  = 4'(K * K - 1);
  localparam logic [3:0] KC_LAST = 4'(K - 1);

  logic [3:0] row_q, row_d;
  logic [3:0] col_q, col_d;
  logic [3:0] k_q, k_d;
  // kr/kc are tracked alongside k so no divider is needed for k/K, k%K.
  logic [3:0] kr_q, kr_d;
  logic [3:0] kc_q, kc_d;

  assign k_idx    = k_q;
  assign k_last   = (k_q == K_LAST);
  assign win_last = (row_q == OH_LAST) && (col_q == OW_LAST);
  assign row      = row_q;
  assign col      = col_q;
  assign addr     = ADDR_W'(addr_of(32'(row_q), 32'(col_q), 32'(kr_q),
                                    32'(kc_q), 32'(IMG_W)));

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    k_d   = k_q;
    kr_d  = kr_q;
    kc_d  = kc_q;
    if (clr) begin
      row_d = '0;
      col_d = '0;
      k_d   = '0;
      kr_d  = '0;
      kc_d  = '0;
    end else begin
      if (k_step) begin
        if (k_last) begin
          k_d  = '0;
          kr_d = '0;
          kc_d = '0;
        end else begin
          k_d = k_q + 4'd1;
          if (kc_q == KC_LAST) begin
            kc_d = '0;
            kr_d = kr_q + 4'd1;
          end else begin
            kc_d = kc_q + 4'd1;
          end
        end
      end
      if (win_adv) begin
        if (col_q == OW_LAST) begin
          col_d = '0;
          row_d = (row_q == OH_LAST) ? 4'd0 : row_q + 4'd1;
        end else begin
          col_d = col_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      row_q <= '0;
      col_q <= '0;
      k_q   <= '0;
      kr_q  <= '0;
      kc_q  <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      k_q   <= k_d;
      kr_q  <= kr_d;
      kc_q  <= kc_d;
    end
  end

endmodule

// File: rtl/conv_window_feeder.sv
// Walks every KxK window of the feature map, streams pixel/weight pairs to the PE, returns results.
// Latency: K*K feed + 1 drain + PE latency + 1 emit cycles per window; pixel follows its read by 1 cycle.
// Backpressure: full stall in EMIT while res_ready=0; no buffer reads are issued during the stall.
// Ports: clk, rst (sync, active-low); start/busy/done/err control; flt_* filter
//   write port (IDLE only); img_* synchronous-read buffer port; pe_* PE drive and
//   result; res_* ready/valid result with its output row/column.
module conv_window_feeder
  import conv_pkg::*;
#(
  parameter int DATA_W  = conv_pkg::DATA_W,
  parameter int IMG_W   = 5,
  parameter int IMG_H   = 5,
  parameter int K       = conv_pkg::K,
  parameter int TIMEOUT = 32,
  parameter int ADDR_W  = $clog2(IMG_W * IMG_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              flt_wr_en,
  input  logic [3:0]        flt_addr,
  input  logic [DATA_W-1:0] flt_data,
  output logic              img_rd_en,
  output logic [ADDR_W-1:0] img_addr,
  input  logic [DATA_W-1:0] img_data,
  output logic [DATA_W-1:0] pe_in,
  output logic [DATA_W-1:0] pe_filter,
  output logic              pe_in_valid,
  input  logic [DATA_W-1:0] pe_out,
  input  logic              pe_valid,
  output logic [DATA_W-1:0] res_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [3:0]        res_row,
  output logic [3:0]        res_col
);

  localparam int KK_L   = K * K;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] wgt_q [KK_L];
  logic [DATA_W-1:0] wgt_d [KK_L];
  logic              pe_vld_q, pe_vld_d;
  logic [DATA_W-1:0] pe_flt_q, pe_flt_d;
  logic [DATA_W-1:0] pix_hold_q, pix_hold_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [3:0]        res_row_q, res_row_d;
  logic [3:0]        res_col_q, res_col_d;

  logic              ag_clr, ag_k_step, ag_win_adv;
  logic [3:0]        k_idx, win_row, win_col;
  logic              k_last, win_last;
  logic [ADDR_W-1:0] ag_addr;
  logic              rd;

  conv_window_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .K      (K),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .clr      (ag_clr),
    .k_step   (ag_k_step),
    .win_adv  (ag_win_adv),
    .k_idx    (k_idx),
    .k_last   (k_last),
    .win_last (win_last),
    .row      (win_row),
    .col      (win_col),
    .addr     (ag_addr)
  );

  assign rd = (state_q == FEED);

  // Next-state and control.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    err_d      = err_q;
    res_data_d = res_data_q;
    res_row_d  = res_row_q;
    res_col_d  = res_col_q;
    ag_clr     = 1'b0;
    ag_k_step  = 1'b0;
    ag_win_adv = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          err_d   = 1'b0;
          ag_clr  = 1'b1;
          state_d = FEED;
        end
      end
      FEED: begin
        ag_k_step = 1'b1;
        if (k_last) state_d = DRAIN;
      end
      DRAIN: begin
        wait_d  = '0;
        state_d = WAIT_PE;
      end
      WAIT_PE: begin
        // A PE result arriving on the last allowed cycle still counts.
        if (pe_valid) begin
          res_data_d = pe_out;
          res_row_d  = win_row;
          res_col_d  = win_col;
          state_d    = EMIT;
        end else if (wait_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      EMIT: begin
        if (res_ready) begin
          ag_win_adv = 1'b1;
          state_d    = win_last ? DONE : FEED;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Filter writes and PE-side datapath.
  always_comb begin
    wgt_d = wgt_q;
    if ((state_q == IDLE) && flt_wr_en && (flt_addr < 4'(KK_L))) begin
      wgt_d[flt_addr] = flt_data;
    end
    // Weight is registered on the read cycle so it lands with the returned pixel.
    pe_vld_d   = rd;
    pe_flt_d   = rd ? wgt_q[k_idx] : pe_flt_q;
    pix_hold_d = pe_vld_q ? img_data : pix_hold_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      err_q      <= 1'b0;
      pe_vld_q   <= 1'b0;
      pe_flt_q   <= '0;
      pix_hold_q <= '0;
      res_data_q <= '0;
      res_row_q  <= '0;
      res_col_q  <= '0;
      for (int i = 0; i < KK_L; i++) wgt_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      err_q      <= err_d;
      pe_vld_q   <= pe_vld_d;
      pe_flt_q   <= pe_flt_d;
      pix_hold_q <= pix_hold_d;
      res_data_q <= res_data_d;
      res_row_q  <= res_row_d;
      res_col_q  <= res_col_d;
      wgt_q      <= wgt_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign err         = err_q;
  assign img_rd_en   = rd;
  assign img_addr    = rd ? ag_addr : '0;
  // Live pixel comes straight from the buffer; afterwards the last one is held.
  assign pe_in       = pe_vld_q ? img_data : pix_hold_q;
  assign pe_filter   = pe_flt_q;
  assign pe_in_valid = pe_vld_q;
  assign res_valid   = (state_q == EMIT);
  assign res_data    = res_data_q;
  assign res_row     = res_row_q;
  assign res_col     = res_col_q;

endmodule

// File: tb/tb_conv_window_feeder.sv
module tb_conv_window_feeder;

  localparam int DW     = 8;
  localparam int TO     = 32;
  localparam int AW     = 5;
  localparam int PE_LAT = 2;
  localparam int BUDGET = 2000;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, err;
  logic          flt_wr_en = 1'b0;
  logic [3:0]    flt_addr = '0;
  logic [DW-1:0] flt_data = '0;
  logic          img_rd_en;
  logic [AW-1:0] img_addr;
  logic [DW-1:0] img_data = '0;
  logic [DW-1:0] pe_in, pe_filter;
  logic          pe_in_valid;
  logic [DW-1:0] pe_out = '0;
  logic          pe_valid = 1'b0;
  logic [DW-1:0] res_data;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [3:0]    res_row, res_col;

  conv_window_feeder #(
    .DATA_W (DW), .IMG_W (5), .IMG_H (5), .K (3), .TIMEOUT (TO), .ADDR_W (AW)
  ) dut (
    .clk (clk), .rst (rst), .start (start), .busy (busy), .done (done), .err (err),
    .flt_wr_en (flt_wr_en), .flt_addr (flt_addr), .flt_data (flt_data),
    .img_rd_en (img_rd_en), .img_addr (img_addr), .img_data (img_data),
    .pe_in (pe_in), .pe_filter (pe_filter), .pe_in_valid (pe_in_valid),
    .pe_out (pe_out), .pe_valid (pe_valid),
    .res_data (res_data), .res_valid (res_valid), .res_ready (res_ready),
    .res_row (res_row), .res_col (res_col)
  );

  int total = 0;
  int bad = 0;
  int hs_cnt = 0;
  int done_cnt = 0;

  typedef struct {
    logic [7:0] data;
    logic [3:0] row;
    logic [3:0] col;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  // Hand-computed window sums over img[i]=i, 5x5, row-major windows.
  int ONES[9] = '{54, 63, 72, 99, 108, 117, 144, 153, 162};
  int HOT4[9] = '{6, 7, 8, 11, 12, 13, 16, 17, 18};
  int ZERO[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  // Synchronous-read image buffer holding img[i]=i.
  always @(posedge clk) if (img_rd_en) img_data <= 8'(img_addr);

  // PE model: sums K*K pairs, reports PE_LAT cycles after the last pair.
  int         pe_cnt = 0;
  int         pe_pend = 0;
  logic [7:0] pe_acc = '0;
  logic [7:0] pe_res = '0;
  bit         pe_mute = 1'b0;
  bit         spur_req = 1'b0;
  always @(negedge clk) begin
    pe_valid = 1'b0;
    if (!rst) begin
      pe_cnt  = 0;
      pe_pend = 0;
      pe_acc  = '0;
    end else begin
      if (spur_req) begin
        pe_valid = 1'b1;
        pe_out   = 8'd200;
        spur_req = 1'b0;
      end
      if (pe_pend > 0) begin
        pe_pend--;
        if (pe_pend == 0 && !pe_mute) begin
          pe_valid = 1'b1;
          pe_out   = pe_res;
        end
      end
      if (pe_in_valid) begin
        pe_acc = pe_acc + pe_in * pe_filter;
        pe_cnt++;
        if (pe_cnt == 9) begin
          pe_res  = pe_acc;
          pe_acc  = '0;
          pe_cnt  = 0;
          pe_pend = PE_LAT;
        end
      end
    end
  end

  // Monitor: compare every accepted result against the scoreboard.
  always @(negedge clk) begin
    if (rst && done) done_cnt++;
    if (rst && res_valid && res_ready) begin
      hs_cnt++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_empty: got result %0d at (%0d,%0d), want none",
                 res_data, res_row, res_col);
      end else begin
        mon_e = sb.pop_front();
        chk("res_data", int'(res_data), int'(mon_e.data));
        chk("res_row", int'(res_row), int'(mon_e.row));
        chk("res_col", int'(res_col), int'(mon_e.col));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int tbl[9], input int n);
    for (int i = 0; i < n; i++)
      sb.push_back('{8'(tbl[i]), 4'(i / 3), 4'(i % 3)});
  endtask

  task automatic wr_flt(input int idx, input int val);
    flt_wr_en = 1'b1;
    flt_addr  = 4'(idx);
    flt_data  = 8'(val);
    step();
    flt_wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (n >= BUDGET) chk({name, "_done_timeout"}, n, -1);
    @(negedge clk);
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_busy"}, int'(busy), 0);
    chk({p, "_done"}, int'(done), 0);
    chk({p, "_err"}, int'(err), 0);
    chk({p, "_rd_en"}, int'(img_rd_en), 0);
    chk({p, "_addr"}, int'(img_addr), 0);
    chk({p, "_pe_in"}, int'(pe_in), 0);
    chk({p, "_pe_filter"}, int'(pe_filter), 0);
    chk({p, "_pe_in_valid"}, int'(pe_in_valid), 0);
    chk({p, "_res_valid"}, int'(res_valid), 0);
    chk({p, "_res_data"}, int'(res_data), 0);
    chk({p, "_res_row"}, int'(res_row), 0);
    chk({p, "_res_col"}, int'(res_col), 0);
  endtask

  initial begin
    int d0, h0, n, c;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    step();
    rst = 1'b1;

    // All-ones filter; out-of-range writes must be dropped.
    for (int i = 0; i < 9; i++) wr_flt(i, 1);
    wr_flt(9, 50);
    wr_flt(15, 50);

    // Full pass, all-ones filter.
    push_exp(ONES, 9);
    d0 = done_cnt;
    pulse_start();
    @(negedge clk);
    chk("busy_after_start", int'(busy), 1);
    wait_done("ones");
    chk("ones_done_count", done_cnt - d0, 1);
    chk("ones_done_pulse", int'(done), 0);
    chk("ones_busy_after", int'(busy), 0);
    chk("ones_err", int'(err), 0);
    chk("ones_sb_left", sb.size(), 0);

    // One-hot centre filter, written together with start on the same cycle.
    for (int i = 0; i < 8; i++) wr_flt(i, (i == 4) ? 1 : 0);
    push_exp(HOT4, 9);
    flt_wr_en = 1'b1;
    flt_addr  = 4'd8;
    flt_data  = 8'd0;
    pulse_start();
    flt_wr_en = 1'b0;
    wait_done("hot4");
    chk("hot4_sb_left", sb.size(), 0);

    // Back to all ones; start and filter write while busy are ignored.
    for (int i = 0; i < 9; i++) wr_flt(i, 1);
    push_exp(ONES, 9);
    d0 = done_cnt;
    pulse_start();
    repeat (5) step();
    flt_wr_en = 1'b1;
    flt_addr  = 4'd0;
    flt_data  = 8'd5;
    pulse_start();
    flt_wr_en = 1'b0;
    wait_done("busy_ign");
    repeat (20) @(negedge clk);
    chk("busy_ign_no_restart", int'(busy), 0);
    chk("busy_ign_done_count", done_cnt - d0, 1);
    chk("busy_ign_sb_left", sb.size(), 0);

    // Backpressure on the first result, with a stray pe_valid during the stall.
    res_ready = 1'b0;
    push_exp(ONES, 9);
    pulse_start();
    n = 0;
    while (!res_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reached_emit", int'(res_valid), 1);
    spur_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_res_valid", int'(res_valid), 1);
      chk("bp_res_data", int'(res_data), 54);
      chk("bp_no_read", int'(img_rd_en), 0);
    end
    step();
    res_ready = 1'b1;
    wait_done("bp");
    chk("bp_sb_left", sb.size(), 0);

    // PE never answers: timeout after exactly TO cycles in WAIT_PE.
    pe_mute = 1'b1;
    d0 = done_cnt;
    pulse_start();
    n = 0;
    while (!pe_in_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    while (pe_in_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("to_feed_seen", int'(n < 60), 1);
    c = 0;
    while (!err && c < TO + 10) begin
      @(negedge clk);
      c++;
    end
    chk("to_cycles", c, TO);
    chk("to_done_with_err", int'(done), 1);
    @(negedge clk);
    chk("to_err_sticky", int'(err), 1);
    chk("to_idle", int'(busy), 0);
    chk("to_done_count", done_cnt - d0, 1);
    pe_mute = 1'b0;
    step();
    push_exp(ONES, 9);
    pulse_start();
    @(negedge clk);
    chk("to_err_cleared", int'(err), 0);
    wait_done("to_rerun");
    chk("to_rerun_sb_left", sb.size(), 0);

    // Reset during FEED of window 4.
    push_exp(ONES, 4);
    h0 = hs_cnt;
    pulse_start();
    n = 0;
    while (hs_cnt < h0 + 4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rst_four_results", hs_cnt - h0, 4);
    step();
    step();
    chk("rst_in_feed", int'(img_rd_en), 1);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_zero("midrst");
    step();
    rst = 1'b1;
    chk("rst_sb_left", sb.size(), 0);

    // Filter was cleared by reset: every window sums to zero.
    push_exp(ZERO, 9);
    pulse_start();
    wait_done("cleared_flt");
    chk("cleared_sb_left", sb.size(), 0);

    // Re-written filter reruns from (0,0).
    for (int i = 0; i < 9; i++) wr_flt(i, 1);
    push_exp(ONES, 9);
    pulse_start();
    wait_done("post_rst");
    chk("post_rst_sb_left", sb.size(), 0);
    chk("post_rst_err", int'(err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
